// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one multi-cycle ALU between two requesters.
// Optional divide-by-zero trap: define ALU_ARB_DIVZ_CHK_EN.
module alu_arbiter #(
  parameter int unsigned ALU_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [3:0]  req0_cmd,
  input  logic [7:0]  req0_a,
  input  logic [7:0]  req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [3:0]  req1_cmd,
  input  logic [7:0]  req1_a,
  input  logic [7:0]  req1_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic        rsp_id,
  output logic        rsp_err,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [3:0]  alu_cmd,
  output logic        alu_en,
  input  logic [15:0] alu_out,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] LAT_L = 4'(ALU_LAT);

  state_t      state_r;
  state_t      state_nxt_s;
  logic        last_grant_r;
  logic        id_r;
  logic [3:0]  cnt_r;
  logic        gnt_valid_s;
  logic        gnt_id_s;
  logic [3:0]  sel_cmd_s;
  logic [7:0]  sel_a_s;
  logic [7:0]  sel_b_s;
  logic        divz_s;
  logic        done_s;
  logic        handoff_s;

  // Grant: only in IDLE; on contention the requester that did not win last time goes first.
  always_comb begin
    gnt_valid_s = 1'b0;
    gnt_id_s    = 1'b0;
    if (state_r == IDLE) begin
      if (req0_valid && req1_valid) begin
        gnt_valid_s = 1'b1;
        gnt_id_s    = ~last_grant_r;
      end else if (req0_valid) begin
        gnt_valid_s = 1'b1;
        gnt_id_s    = 1'b0;
      end else if (req1_valid) begin
        gnt_valid_s = 1'b1;
        gnt_id_s    = 1'b1;
      end else begin
        gnt_valid_s = 1'b0;
        gnt_id_s    = 1'b0;
      end
    end else begin
      gnt_valid_s = 1'b0;
      gnt_id_s    = 1'b0;
    end
  end

  assign req0_ready = gnt_valid_s & ~gnt_id_s;
  assign req1_ready = gnt_valid_s &  gnt_id_s;

  // Operand mux for the granted requester.
  always_comb begin
    sel_cmd_s = req0_cmd;
    sel_a_s   = req0_a;
    sel_b_s   = req0_b;
    if (gnt_id_s) begin
      sel_cmd_s = req1_cmd;
      sel_a_s   = req1_a;
      sel_b_s   = req1_b;
    end else begin
      sel_cmd_s = req0_cmd;
      sel_a_s   = req0_a;
      sel_b_s   = req0_b;
    end
  end

`ifdef ALU_ARB_DIVZ_CHK_EN
  localparam logic [3:0] CMD_DIV = 4'b0101;
  assign divz_s = gnt_valid_s && (sel_cmd_s == CMD_DIV) && (sel_b_s == 8'h00);
`else
  assign divz_s = 1'b0;
`endif

  assign done_s    = (state_r == EXEC) && (cnt_r == 4'd1);
  assign handoff_s = (state_r == RESP) && rsp_ready;
  assign busy      = (state_r != IDLE);

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (divz_s) begin
          state_nxt_s = RESP;
        end else if (gnt_valid_s) begin
          state_nxt_s = EXEC;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      EXEC: begin
        if (done_s) begin
          state_nxt_s = RESP;
        end else begin
          state_nxt_s = EXEC;
        end
      end
      RESP: begin
        if (handoff_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = RESP;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Datapath: operand latch, latency counter, result capture and response handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_r <= 1'b1;
      id_r         <= 1'b0;
      cnt_r        <= 4'd0;
      alu_a        <= 8'h00;
      alu_b        <= 8'h00;
      alu_cmd      <= 4'h0;
      alu_en       <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_data     <= 16'h0000;
      rsp_id       <= 1'b0;
    end else begin
      if (gnt_valid_s) begin
        alu_a   <= sel_a_s;
        alu_b   <= sel_b_s;
        alu_cmd <= sel_cmd_s;
        id_r    <= gnt_id_s;
        cnt_r   <= LAT_L;
        if (divz_s) begin
          alu_en    <= 1'b0;
          rsp_valid <= 1'b1;
          rsp_data  <= 16'hFFFF;
          rsp_id    <= gnt_id_s;
        end else begin
          alu_en <= 1'b1;
        end
      end else if (done_s) begin
        alu_en    <= 1'b0;
        rsp_valid <= 1'b1;
        rsp_data  <= alu_out;
        rsp_id    <= id_r;
      end else if (state_r == EXEC) begin
        cnt_r <= cnt_r - 4'd1;
      end else if (handoff_s) begin
        rsp_valid    <= 1'b0;
        last_grant_r <= rsp_id;
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

`ifdef ALU_ARB_DIVZ_CHK_EN
  // Error flag: set by a trapped divide, cleared whenever a normal result is loaded.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_err <= 1'b0;
    end else if (divz_s) begin
      rsp_err <= 1'b1;
    end else if (done_s) begin
      rsp_err <= 1'b0;
    end else begin
      rsp_err <= rsp_err;
    end
  end
`else
  assign rsp_err = 1'b0;
`endif

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one 8-bit ALU (4-bit command, 16-bit result, tri-stated when disabled) between two requesters.
- Round-robin arbitration with valid/ready handshakes on each request port and on the single response port.
- Drives the ALU's operand, command and enable inputs, waits a configured number of cycles, captures the result, and returns it tagged with the requester ID.

Parameters:
- ALU_LAT, 1: cycles alu_en and operands are held before alu_out is sampled. Legal range 1..15.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- req0_valid  input  1  requester 0 has an operation.
- req0_ready  output  1  requester 0 operation accepted this cycle.
- req0_cmd  input  4  ALU command.
- req0_a, req0_b  input  8 each  operands.
- req1_valid, req1_ready, req1_cmd, req1_a, req1_b  same as requester 0.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer takes the result.
- rsp_data  output  16  captured ALU result.
- rsp_id  output  1  requester that issued the operation.
- rsp_err  output  1  error flag (see Optional Feature).
- alu_a, alu_b  output  8 each  ALU operands.
- alu_cmd  output  4  ALU command.
- alu_en  output  1  ALU enable.
- alu_out  input  16  ALU result.
- busy  output  1  high whenever the state is not IDLE.

Behaviour:
- Reset values: state IDLE, last_grant=1 (requester 0 wins the first contest).
- Registered outputs reset to 0: rsp_valid, rsp_data, rsp_id, rsp_err, alu_a, alu_b, alu_cmd, alu_en. busy reset value is 0.
- Reset mid-operation: the transaction in flight is abandoned and no response is produced. Every output is at its reset value after the rst edge.
- Grant (combinational, IDLE only):
  - Only one valid: grant that requester.
  - Both valid: grant the requester != last_grant.
  - req*_ready = (state==IDLE) && granted. At most one ready is high at a time. Ready may depend combinationally on valid.
- Accept: on the edge where valid&&ready:
  - latch cmd, a and b into alu_cmd, alu_a and alu_b; latch id;
  - load cnt=ALU_LAT; go to EXEC.
- EXEC:
  - alu_en=1; alu_a, alu_b and alu_cmd stable; both req*_ready=0.
  - cnt decrements each edge.
  - On the edge with cnt==1: rsp_data<=alu_out, rsp_id<=id, rsp_valid<=1, alu_en<=0, go to RESP.
  - rsp_valid therefore rises ALU_LAT edges after the accept edge.
- RESP:
  - rsp_valid=1; rsp_data, rsp_id and rsp_err held stable until the handshake.
  - On rsp_valid&&rsp_ready: rsp_valid<=0, last_grant<=rsp_id, go to IDLE.
  - Back-pressure of any length is legal.
- Throughput: there is at least one IDLE cycle between operations, so one operation completes per ALU_LAT+2 cycles at best.
- Outside EXEC:
  - alu_en=0, so alu_out is high-Z and is never sampled.
  - alu_a, alu_b and alu_cmd hold their last values.
- Commands are passed through unchanged; the block does not decode them (except the DIV check below). alu_out is taken as 16 bits with no extension or truncation.

Optional Feature:
- Macro: ALU_ARB_DIVZ_CHK_EN.
- Defined:
  - On accept, if cmd==4'b0101 (DIV) and b==8'h00, skip EXEC and go directly to RESP.
  - Response is rsp_data=16'hFFFF, rsp_err=1.
  - alu_en is never asserted for that operation.
  - rsp_err clears when the next response is loaded.
- Undefined:
  - rsp_err is tied to 0.
  - DIV by zero is issued to the ALU like any other command; rsp_data is whatever alu_out returns.

Test Plan:
- ALU_LAT=1, real ALU attached, after reset: req0 ADD a=8'h05 b=8'h03 -> rsp_valid one edge after accept, rsp_data=16'h0008, rsp_id=0, rsp_err=0.
- Both requesters valid in the same cycle:
  - req0 MUL a=8'h10 b=8'h10; req1 SUB a=8'h09 b=8'h04.
  - Expect req0 served first (16'h0100, id 0), then req1 (16'h0005, id 1).
  - Repeat with both valid again: req1 is no longer favoured, so req0 wins.
- rsp_ready held low 5 cycles in RESP -> rsp_valid, rsp_data and rsp_id stable; req0_ready=req1_ready=0; alu_en=0; busy=1.
- ALU_LAT=3, req1 INC a=8'hFF -> alu_en high exactly 3 cycles; rsp_valid on the 3rd edge after accept; rsp_data=16'h0100.
- rst asserted for one cycle during EXEC -> next cycle all outputs 0 and no rsp_valid. A following req0 XOR 8'hF0,8'h0F returns 16'h00FF.
- req0 DIV a=8'h0A b=8'h00:
  - Macro defined -> rsp_err=1, rsp_data=16'hFFFF, alu_en never high.
  - Macro undefined -> alu_en pulses and rsp_err=0.
